// File: rtl/spdif_tx_ctrl.sv
// S/PDIF sample scheduler: buffers one stereo pair, answers L/R pops, builds channel-status block.
// Latency: ack_o/data_o one cycle after pop_i; cdata_o one cycle after cfg_load_i.
// Backpressure: in_ready_o low while the pair buffer is full unless its right sample is served now.
// Optional SPDIF_TX_CTRL_HOLD_EN: mute repeats the last acked sample instead of zero.
module spdif_tx_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [47:0]      in_data_i,
  input  logic [1:0]       pop_i,
  output logic [1:0]       ack_o,
  output logic [47:0]      data_o,
  output logic [191:0]     cdata_o,
  output logic [191:0]     udata_o,
  input  logic             cfg_load_i,
  input  logic             cfg_copy_i,
  input  logic             cfg_preemph_i,
  input  logic [3:0]       cfg_fs_i,
  input  logic [3:0]       cfg_wlen_i,
  output logic             underrun_o,
  output logic [CNT_W-1:0] underrun_cnt_o,
  output logic [CNT_W-1:0] syncerr_cnt_o
);

  typedef enum logic [1:0] {EXP_L, EXP_R_LIVE, EXP_R_MUTE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t        state, state_nxt;
  logic [47:0]   pair_q;
  logic          pair_vld;
  logic          pop_l, pop_r;
  logic          live_l, live_r, underrun_ev, syncerr_ev;
  logic [23:0]   mute_l, mute_r;
  logic [191:0]  cfg_blk;

  // Simultaneous pops are treated as a left pop.
  assign pop_l = pop_i[0];
  assign pop_r = pop_i[1] & ~pop_i[0];

  assign in_ready_o = ~rst & en_i & (~pair_vld | live_r);
  assign udata_o    = '0;

`ifdef SPDIF_TX_CTRL_HOLD_EN
  assign mute_l = en_i ? data_o[23:0]  : 24'h000000;
  assign mute_r = en_i ? data_o[47:24] : 24'h000000;
`else
  assign mute_l = 24'h000000;
  assign mute_r = 24'h000000;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= EXP_L;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en_i) begin
      state_nxt = EXP_L;
    end else begin
      case (state)
        EXP_L: begin
          if (pop_l) state_nxt = pair_vld ? EXP_R_LIVE : EXP_R_MUTE;
        end
        default: begin
          if (pop_l)      state_nxt = EXP_R_MUTE;
          else if (pop_r) state_nxt = EXP_L;
        end
      endcase
    end
  end

  always_comb begin
    live_l      = 1'b0;
    live_r      = 1'b0;
    underrun_ev = 1'b0;
    syncerr_ev  = 1'b0;
    if (en_i) begin
      case (state)
        EXP_L: begin
          live_l      = pop_l & pair_vld;
          underrun_ev = pop_l & ~pair_vld;
          syncerr_ev  = pop_r | (pop_i == 2'b11);
        end
        EXP_R_LIVE: begin
          live_r     = pop_r;
          syncerr_ev = pop_l;
        end
        EXP_R_MUTE: begin
          syncerr_ev = pop_l;
        end
        default: ;
      endcase
    end
  end

  // IEC bit n lives at cdata_o[191-n], so multi-bit fields appear bit-reversed.
  always_comb begin
    cfg_blk          = '0;
    cfg_blk[189]     = cfg_copy_i;
    cfg_blk[188]     = cfg_preemph_i;
    cfg_blk[167:164] = {cfg_fs_i[0], cfg_fs_i[1], cfg_fs_i[2], cfg_fs_i[3]};
    cfg_blk[159:156] = {cfg_wlen_i[0], cfg_wlen_i[1], cfg_wlen_i[2], cfg_wlen_i[3]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_o          <= 2'b00;
      data_o         <= '0;
      underrun_o     <= 1'b0;
      underrun_cnt_o <= '0;
      syncerr_cnt_o  <= '0;
      pair_q         <= '0;
      pair_vld       <= 1'b0;
      cdata_o        <= '0;
    end else begin
      ack_o      <= {pop_r, pop_l};
      underrun_o <= underrun_ev;
      if (pop_l) data_o[23:0]  <= live_l ? pair_q[23:0]  : mute_l;
      if (pop_r) data_o[47:24] <= live_r ? pair_q[47:24] : mute_r;
      if (underrun_ev && (underrun_cnt_o != '1)) underrun_cnt_o <= underrun_cnt_o + CNT_ONE;
      if (syncerr_ev && (syncerr_cnt_o != '1))   syncerr_cnt_o  <= syncerr_cnt_o + CNT_ONE;
      if (!en_i) begin
        pair_vld <= 1'b0;
      end else if (in_valid_i && in_ready_o) begin
        pair_q   <= in_data_i;
        pair_vld <= 1'b1;
      end else if (live_r) begin
        pair_vld <= 1'b0;
      end
      if (cfg_load_i) cdata_o <= cfg_blk;
    end
  end

endmodule

// File: tb/tb_spdif_tx_ctrl.sv
// Directed bench for spdif_tx_ctrl; expectations follow SPDIF_TX_CTRL_HOLD_EN if defined.
module tb_spdif_tx_ctrl;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             en_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [47:0]      in_data_i;
  logic [1:0]       pop_i;
  logic [1:0]       ack_o;
  logic [47:0]      data_o;
  logic [191:0]     cdata_o;
  logic [191:0]     udata_o;
  logic             cfg_load_i;
  logic             cfg_copy_i;
  logic             cfg_preemph_i;
  logic [3:0]       cfg_fs_i;
  logic [3:0]       cfg_wlen_i;
  logic             underrun_o;
  logic [CNT_W-1:0] underrun_cnt_o;
  logic [CNT_W-1:0] syncerr_cnt_o;

  int total = 0;
  int bad   = 0;

  spdif_tx_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en_i(en_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .pop_i(pop_i), .ack_o(ack_o), .data_o(data_o),
    .cdata_o(cdata_o), .udata_o(udata_o),
    .cfg_load_i(cfg_load_i), .cfg_copy_i(cfg_copy_i), .cfg_preemph_i(cfg_preemph_i),
    .cfg_fs_i(cfg_fs_i), .cfg_wlen_i(cfg_wlen_i),
    .underrun_o(underrun_o), .underrun_cnt_o(underrun_cnt_o), .syncerr_cnt_o(syncerr_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop(input logic [1:0] p);
    pop_i = p;
    tick();
    pop_i = 2'b00;
  endtask

  task automatic load_pair(input logic [47:0] d);
    in_data_i  = d;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", in_ready_o); end
    total++; if (ack_o !== 2'b00) begin bad++; $display("FAIL rst_ack got=%b exp=00", ack_o); end
    total++; if (data_o !== 48'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", data_o); end
    total++; if (underrun_o !== 1'b0 || underrun_cnt_o !== 16'd0 || syncerr_cnt_o !== 16'd0) begin
      bad++; $display("FAIL rst_cnt got=%b/%0d/%0d exp=0/0/0", underrun_o, underrun_cnt_o, syncerr_cnt_o);
    end
    total++; if (cdata_o !== 192'h0 || udata_o !== 192'h0) begin bad++; $display("FAIL rst_cdata got=%h exp=0", cdata_o); end
    rst = 1'b0;
    #1;
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", in_ready_o); end
  endtask

  task automatic test_basic();
    load_pair(48'hABCDEF_123456);
    total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL basic_full_ready got=%b exp=0", in_ready_o); end
    pop(2'b01);
    total++; if (ack_o !== 2'b01 || data_o[23:0] !== 24'h123456) begin
      bad++; $display("FAIL basic_left got=%b/%h exp=01/123456", ack_o, data_o[23:0]);
    end
    tick();
    total++; if (ack_o !== 2'b00) begin bad++; $display("FAIL basic_ack_width got=%b exp=00", ack_o); end
    repeat (62) tick();
    pop_i = 2'b10;
    #1;
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL basic_ready_on_right got=%b exp=1", in_ready_o); end
    tick();
    pop_i = 2'b00;
    total++; if (ack_o !== 2'b10 || data_o !== 48'hABCDEF_123456) begin
      bad++; $display("FAIL basic_right got=%b/%h exp=10/abcdef123456", ack_o, data_o);
    end
  endtask

  task automatic test_underrun();
    logic [23:0] exp_l, exp_r;
`ifdef SPDIF_TX_CTRL_HOLD_EN
    exp_l = 24'h123456;
    exp_r = 24'hABCDEF;
`else
    exp_l = 24'h000000;
    exp_r = 24'h000000;
`endif
    tick();
    pop(2'b01);
    total++; if (ack_o !== 2'b01 || data_o[23:0] !== exp_l) begin
      bad++; $display("FAIL underrun_left got=%b/%h exp=01/%h", ack_o, data_o[23:0], exp_l);
    end
    total++; if (underrun_o !== 1'b1 || underrun_cnt_o !== 16'd1) begin
      bad++; $display("FAIL underrun_flag got=%b/%0d exp=1/1", underrun_o, underrun_cnt_o);
    end
    tick();
    total++; if (underrun_o !== 1'b0) begin bad++; $display("FAIL underrun_pulse got=%b exp=0", underrun_o); end
    load_pair(48'h111111_222222);
    pop(2'b10);
    total++; if (ack_o !== 2'b10 || data_o[47:24] !== exp_r) begin
      bad++; $display("FAIL underrun_right_mute got=%b/%h exp=10/%h", ack_o, data_o[47:24], exp_r);
    end
    pop(2'b01);
    total++; if (data_o[23:0] !== 24'h222222 || underrun_cnt_o !== 16'd1) begin
      bad++; $display("FAIL underrun_next_left got=%h/%0d exp=222222/1", data_o[23:0], underrun_cnt_o);
    end
    pop(2'b10);
    total++; if (data_o[47:24] !== 24'h111111) begin
      bad++; $display("FAIL underrun_next_right got=%h exp=111111", data_o[47:24]);
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] pairs [4];
    for (int k = 0; k < 4; k++) pairs[k] = {24'hA00000 + 24'(k), 24'hB00000 + 24'(k)};
    load_pair(pairs[0]);
    for (int k = 0; k < 4; k++) begin
      pop(2'b01);
      total++; if (ack_o !== 2'b01 || data_o[23:0] !== pairs[k][23:0]) begin
        bad++; $display("FAIL b2b_left%0d got=%b/%h exp=01/%h", k, ack_o, data_o[23:0], pairs[k][23:0]);
      end
      pop_i = 2'b10;
      if (k < 3) begin
        in_valid_i = 1'b1;
        in_data_i  = pairs[k+1];
      end
      #1;
      total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b exp=1", k, in_ready_o); end
      tick();
      pop_i      = 2'b00;
      in_valid_i = 1'b0;
      total++; if (ack_o !== 2'b10 || data_o[47:24] !== pairs[k][47:24]) begin
        bad++; $display("FAIL b2b_right%0d got=%b/%h exp=10/%h", k, ack_o, data_o[47:24], pairs[k][47:24]);
      end
      tick();
    end
    total++; if (underrun_cnt_o !== 16'd1) begin bad++; $display("FAIL b2b_underruns got=%0d exp=1", underrun_cnt_o); end
  endtask

  task automatic test_syncerr();
    logic [23:0] exp_r;
`ifdef SPDIF_TX_CTRL_HOLD_EN
    exp_r = 24'hA00003;
`else
    exp_r = 24'h000000;
`endif
    load_pair(48'hC0FFEE_BEEF00);
    pop(2'b10);
    total++; if (ack_o !== 2'b10 || data_o[47:24] !== exp_r || syncerr_cnt_o !== 16'd1) begin
      bad++; $display("FAIL sync_right got=%b/%h/%0d exp=10/%h/1", ack_o, data_o[47:24], syncerr_cnt_o, exp_r);
    end
    pop(2'b01);
    total++; if (ack_o !== 2'b01 || data_o[23:0] !== 24'hBEEF00) begin
      bad++; $display("FAIL sync_left_live got=%b/%h exp=01/beef00", ack_o, data_o[23:0]);
    end
    pop(2'b10);
    total++; if (data_o[47:24] !== 24'hC0FFEE || syncerr_cnt_o !== 16'd1 || underrun_cnt_o !== 16'd1) begin
      bad++; $display("FAIL sync_right_live got=%h/%0d/%0d exp=c0ffee/1/1", data_o[47:24], syncerr_cnt_o, underrun_cnt_o);
    end
  endtask

  task automatic test_cfg();
    logic [191:0] exp_c;
    cfg_fs_i   = 4'b0010;
    cfg_wlen_i = 4'b1011;
    cfg_copy_i = 1'b1;
    tick();
    total++; if (cdata_o !== 192'h0) begin bad++; $display("FAIL cfg_preload got=%h exp=0", cdata_o); end
    cfg_load_i = 1'b1;
    tick();
    cfg_load_i = 1'b0;
    exp_c = '0;
    exp_c[189] = 1'b1;
    exp_c[167:164] = 4'b0100;
    exp_c[159:156] = 4'b1101;
    total++; if (cdata_o !== exp_c) begin bad++; $display("FAIL cfg_load1 got=%h exp=%h", cdata_o, exp_c); end
    cfg_fs_i      = 4'b0001;
    cfg_wlen_i    = 4'b0000;
    cfg_copy_i    = 1'b0;
    cfg_preemph_i = 1'b1;
    repeat (3) tick();
    total++; if (cdata_o !== exp_c) begin bad++; $display("FAIL cfg_stable got=%h exp=%h", cdata_o, exp_c); end
    cfg_load_i = 1'b1;
    tick();
    cfg_load_i = 1'b0;
    exp_c = '0;
    exp_c[188] = 1'b1;
    exp_c[167] = 1'b1;
    total++; if (cdata_o !== exp_c) begin bad++; $display("FAIL cfg_load2 got=%h exp=%h", cdata_o, exp_c); end
  endtask

  task automatic test_disable();
    load_pair(48'h123123_456456);
    en_i = 1'b0;
    #1;
    total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL dis_ready got=%b exp=0", in_ready_o); end
    tick();
    pop(2'b01);
    total++; if (ack_o !== 2'b01 || data_o[23:0] !== 24'h0 || underrun_o !== 1'b0) begin
      bad++; $display("FAIL dis_left got=%b/%h/%b exp=01/000000/0", ack_o, data_o[23:0], underrun_o);
    end
    pop(2'b10);
    total++; if (ack_o !== 2'b10 || data_o[47:24] !== 24'h0) begin
      bad++; $display("FAIL dis_right got=%b/%h exp=10/000000", ack_o, data_o[47:24]);
    end
    total++; if (underrun_cnt_o !== 16'd1 || syncerr_cnt_o !== 16'd1) begin
      bad++; $display("FAIL dis_counts got=%0d/%0d exp=1/1", underrun_cnt_o, syncerr_cnt_o);
    end
    en_i = 1'b1;
    #1;
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL dis_flushed got=%b exp=1", in_ready_o); end
    load_pair(48'h777777_888888);
    pop(2'b01);
    total++; if (ack_o !== 2'b01 || data_o[23:0] !== 24'h888888) begin
      bad++; $display("FAIL reen_left got=%b/%h exp=01/888888", ack_o, data_o[23:0]);
    end
    pop(2'b10);
    total++; if (data_o[47:24] !== 24'h777777) begin bad++; $display("FAIL reen_right got=%h exp=777777", data_o[47:24]); end
  endtask

  task automatic test_dual_pop_and_rst();
    load_pair(48'h5A5A5A_A5A5A5);
    pop(2'b11);
    total++; if (ack_o !== 2'b01 || data_o[23:0] !== 24'hA5A5A5 || syncerr_cnt_o !== 16'd2) begin
      bad++; $display("FAIL dual_pop got=%b/%h/%0d exp=01/a5a5a5/2", ack_o, data_o[23:0], syncerr_cnt_o);
    end
    pop_i = 2'b10;
    rst   = 1'b1;
    tick();
    pop_i = 2'b00;
    total++; if (ack_o !== 2'b00 || data_o !== 48'h0 || in_ready_o !== 1'b0) begin
      bad++; $display("FAIL midrst_out got=%b/%h/%b exp=00/0/0", ack_o, data_o, in_ready_o);
    end
    total++; if (syncerr_cnt_o !== 16'd0 || underrun_cnt_o !== 16'd0 || cdata_o !== 192'h0) begin
      bad++; $display("FAIL midrst_state got=%0d/%0d/%h exp=0/0/0", syncerr_cnt_o, underrun_cnt_o, cdata_o);
    end
    rst = 1'b0;
    tick();
    pop(2'b01);
    total++; if (ack_o !== 2'b01 || underrun_cnt_o !== 16'd1) begin
      bad++; $display("FAIL midrst_resume got=%b/%0d exp=01/1", ack_o, underrun_cnt_o);
    end
  endtask

  initial begin
    rst           = 1'b1;
    en_i          = 1'b1;
    in_valid_i    = 1'b0;
    in_data_i     = '0;
    pop_i         = 2'b00;
    cfg_load_i    = 1'b0;
    cfg_copy_i    = 1'b0;
    cfg_preemph_i = 1'b0;
    cfg_fs_i      = 4'b0000;
    cfg_wlen_i    = 4'b0000;
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_syncerr();
    test_cfg();
    test_disable();
    test_dual_pop_and_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
